mem_arbiter: RTL and testbench

Shares the single external memory port between the instruction-fetch miss path (I-side) and the memory-stage data path (D-side). It serialises their requests, counts refill beats and steers returned data to the owning requester. It also produces `stall_from_memory` for the pipeline control block. It sits between the fetch/memory stages and the bus interface, one transaction outstanding at a time.

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter_rr2.sv | 22 ++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types for the memory-port arbiter.
//   arb_state_e       - arbiter FSM state (IDLE / ADDR / DATA)
//   arb_owner_e       - which requester owns the memory port
//   BURST_LEN_DEFAULT - default beats per line refill
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
  typedef enum logic {OWN_I, OWN_D} arb_owner_e;

  localparam int BURST_LEN_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-side, D-side, pipeline-stall and memory-port
// signals of the arbiter.
//   slave  - the arbiter's view (takes requests and memory responses,
//            drives beats/dones to requesters and commands to memory)
//   master - the surrounding environment (requesters + memory model)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // I-side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              flush_if;
  // D-side
  logic              d_req;
  logic              d_we;
  logic              d_burst;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              stall_from_memory;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [7:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, flush_if,
    input  d_req, d_we, d_burst, d_addr, d_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output i_rvalid, i_rdata, i_done,
    output d_rvalid, d_rdata, d_done, stall_from_memory,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, flush_if,
    output d_req, d_we, d_burst, d_addr, d_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  i_rvalid, i_rdata, i_done,
    input  d_rvalid, d_rdata, d_done, stall_from_memory,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: two-input round-robin picker.
//   req_i, req_d - request from I-side / D-side
//   last_grant   - side granted most recently
//   gnt_vld      - some request present
//   gnt          - chosen side; on a tie, the side opposite last_grant
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_owner_e last_grant,
  output logic       gnt_vld,
  output arb_owner_e gnt
);

  always_comb begin
    gnt_vld = req_i | req_d;
    if (req_i && req_d) gnt = (last_grant == OWN_I) ? OWN_D : OWN_I;
    else                gnt = req_d ? OWN_D : OWN_I;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-fetch miss path and the
// D-side memory stage. One transaction in flight; beats are steered to the
// owner combinationally.
//   clk, rst - clock, synchronous active-high reset
//   bus      - mem_arbiter_if.slave: requester sides, flush_if,
//              stall_from_memory and the memory command/response port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int         CNT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [7:0] LINE_LEN = 8'(BURST_LEN - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, last_grant_q, gnt;
  logic              gnt_vld;
  logic [CNT_W-1:0]  cnt_q;
  logic              cancel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [7:0]        len_q;
  logic              beat, last_beat, own_i;

  // A flush in IDLE withholds the I grant for that cycle.
  arb_rr2 u_rr (
    .req_i      (bus.i_req & ~bus.flush_if),
    .req_d      (bus.d_req),
    .last_grant (last_grant_q),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  // A beat counts in DATA, or in ADDR when accept and data coincide.
  assign beat      = bus.mem_data_ok &
                     ((state_q == DATA) || (state_q == ADDR && bus.mem_addr_ok));
  assign last_beat = beat && (cnt_q == len_q[CNT_W-1:0]);
  assign own_i     = (owner_q == OWN_I);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt_vld) state_d = ADDR;
      ADDR: if (bus.mem_addr_ok) state_d = last_beat ? IDLE : DATA;
      DATA: if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.mem_req   = (state_q == ADDR);
    bus.mem_we    = we_q;
    bus.mem_len   = len_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    // A flush arriving with a beat already hides that beat.
    bus.i_rvalid  = beat && own_i && !cancel_q && !bus.flush_if;
    bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.i_done    = last_beat && own_i;
    bus.d_rvalid  = beat && !own_i && !we_q;
    bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
    bus.d_done    = last_beat && !own_i;
    bus.stall_from_memory = bus.d_req && !bus.d_done;
  end

  // transaction registers, beat counter, cancel flag
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      cnt_q        <= '0;
      cancel_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      len_q        <= '0;
    end else begin
      if (state_q == IDLE && gnt_vld) begin
        owner_q      <= gnt;
        last_grant_q <= gnt;
        if (gnt == OWN_D) begin
          addr_q  <= bus.d_addr;
          wdata_q <= bus.d_wdata;
          we_q    <= bus.d_we;
          len_q   <= (!bus.d_we && bus.d_burst) ? LINE_LEN : 8'd0;
        end else begin
          addr_q  <= bus.i_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
          len_q   <= LINE_LEN;
        end
      end
      if (last_beat) begin
        cnt_q    <= '0;
        cancel_q <= 1'b0;
      end else begin
        if (beat) cnt_q <= cnt_q + 1'b1;
        if (bus.flush_if && own_i && state_q != IDLE) cancel_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized transactions.
// The bench plays both requesters and the memory, and predicts grants,
// beat counts and steering from the arbitration rules directly.
module tb_mem_arbiter;

  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  bit   last_d;                 // side granted most recently (1 = D)
  logic [31:0] ia, da, wd;
  bit   ir, dr, we, bu, pend_i, pend_d;
  int   fa;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string t, input bit dreq);
    chk({t, "_i_rvalid"}, bus.i_rvalid, 0);
    chk({t, "_i_done"}, bus.i_done, 0);
    chk({t, "_d_rvalid"}, bus.d_rvalid, 0);
    chk({t, "_d_done"}, bus.d_done, 0);
    chk({t, "_stall"}, bus.stall_from_memory, dreq);
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_mem_req"}, bus.mem_req, 0);
    chk({t, "_mem_we"}, bus.mem_we, 0);
    chk({t, "_mem_len"}, bus.mem_len, 0);
    chk({t, "_mem_addr"}, bus.mem_addr, 0);
    chk({t, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({t, "_i_rdata"}, bus.i_rdata, 0);
    chk({t, "_d_rdata"}, bus.d_rdata, 0);
    chk_quiet(t, 0);
  endtask

  task automatic chk_addr(input logic [31:0] ea, input logic [7:0] elen,
                          input bit ewe, input logic [31:0] ewd);
    chk("addr_mem_req", bus.mem_req, 1);
    chk("addr_mem_addr", bus.mem_addr, ea);
    chk("addr_mem_len", bus.mem_len, elen);
    chk("addr_mem_we", bus.mem_we, ewe);
    if (ewe) chk("addr_mem_wdata", bus.mem_wdata, ewd);
  endtask

  task automatic chk_beat(input bit own_d, input bit ewe, input bit canc,
                          input bit last, input bit dreq, input logic [31:0] rd);
    chk("beat_i_rvalid", bus.i_rvalid, !own_d && !canc);
    chk("beat_i_done", bus.i_done, !own_d && last);
    chk("beat_d_rvalid", bus.d_rvalid, own_d && !ewe);
    chk("beat_d_done", bus.d_done, own_d && last);
    chk("beat_stall", bus.stall_from_memory, dreq && !(own_d && last));
    if (!own_d && !canc) chk("beat_i_rdata", bus.i_rdata, rd);
    if (own_d && !ewe) chk("beat_d_rdata", bus.d_rdata, rd);
  endtask

  // One transaction, entered and left in an IDLE cycle (#1 after the edge).
  // dbase != 0 gives beat data dbase+k, else random. flush_at = beat after
  // which a one-cycle flush is raised; rst_at = beat after which rst is hit.
  task automatic do_txn(input bit ir_, input bit dr_, input bit we_, input bit bu_,
                        input logic [31:0] ia_, input logic [31:0] da_,
                        input logic [31:0] wd_, input logic [31:0] dbase,
                        input int adly, input int g0, input int gmax,
                        input bit same, input int flush_at, input int rst_at);
    bit own_d, ewe, canc;
    int beats, g;
    logic [31:0] ea, rd;
    logic [7:0] elen;
    own_d  = (ir_ && dr_) ? !last_d : dr_;
    last_d = own_d;
    ewe    = own_d && we_;
    beats  = (own_d && (we_ || !bu_)) ? 1 : BL;
    elen   = 8'(beats - 1);
    ea     = own_d ? da_ : ia_;
    canc   = 0;
    bus.i_req = ir_; bus.i_addr = ia_;
    bus.d_req = dr_; bus.d_we = we_; bus.d_burst = bu_;
    bus.d_addr = da_; bus.d_wdata = wd_;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.flush_if = 0;
    @(negedge clk);
    chk("idle_mem_req", bus.mem_req, 0);
    chk_quiet("idle", dr_);
    next();
    for (int c = 0; c < adly; c++) begin
      bus.mem_data_ok = 1'($urandom_range(0, 1));  // must be ignored in ADDR
      bus.mem_rdata = $urandom;
      @(negedge clk);
      chk_addr(ea, elen, ewe, wd_);
      chk_quiet("addr", dr_);
      next();
    end
    rd = (dbase != 0) ? dbase : $urandom;
    bus.mem_addr_ok = 1; bus.mem_data_ok = same; bus.mem_rdata = rd;
    @(negedge clk);
    chk_addr(ea, elen, ewe, wd_);
    if (same) chk_beat(own_d, ewe, canc, beats == 1, dr_, rd);
    else chk_quiet("accept", dr_);
    next();
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0;
    for (int k = same ? 1 : 0; k < beats; k++) begin
      g = (k == 0) ? g0 : $urandom_range(0, gmax);
      if (flush_at >= 0 && k == flush_at + 1 && g == 0) g = 1;
      for (int j = 0; j < g; j++) begin
        bus.flush_if = (flush_at >= 0 && k == flush_at + 1 && j == 0);
        bus.mem_data_ok = 0;
        @(negedge clk);
        chk("data_mem_req", bus.mem_req, 0);
        chk_quiet("gap", dr_);
        next();
        if (bus.flush_if && !own_d) canc = 1;
        bus.flush_if = 0;
      end
      rd = (dbase != 0) ? dbase + 32'(k) : $urandom;
      bus.mem_data_ok = 1; bus.mem_rdata = rd;
      @(negedge clk);
      chk_beat(own_d, ewe, canc, k == beats - 1, dr_, rd);
      next();
      bus.mem_data_ok = 0;
      if (k == rst_at) begin
        rst = 1; bus.i_req = 0; bus.d_req = 0;
        next();
        @(negedge clk);
        chk_zero("rst_data");
        next();
        rst = 0;
        last_d = 0;
        return;
      end
    end
    if (own_d) bus.d_req = 0;
    else bus.i_req = 0;
  endtask

  initial begin
    rst = 1; last_d = 0;
    bus.i_req = 0; bus.i_addr = 0; bus.flush_if = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_burst = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 32'h1234_5678;
    repeat (3) next();
    @(negedge clk);
    chk_zero("reset");
    next();
    rst = 0;

    // I-only line refill: accept at cycle 3, beats A0..A3 on cycles 5-8
    do_txn(1, 0, 0, 0, 32'h1000_0040, 0, 0, 32'hA0, 2, 1, 0, 0, -1, -1);
    // D uncached write
    do_txn(0, 1, 1, 0, 0, 32'hBFC0_0010, 32'hDEAD_BEEF, 0, 1, 0, 1, 0, -1, -1);
    // D single read with accept and data in the same cycle
    do_txn(0, 1, 0, 0, 0, 32'h2000_0004, 0, 32'h55, 0, 0, 1, 1, -1, -1);
    // flush after beat 1 of an I refill
    do_txn(1, 0, 0, 0, 32'h1000_0080, 0, 0, 32'hB0, 1, 0, 0, 0, 1, -1);
    // flush in IDLE holds off the I grant; the following refill is normal
    bus.i_req = 1; bus.i_addr = 32'h1000_00C0; bus.d_req = 0; bus.flush_if = 1;
    @(negedge clk);
    chk("flush_idle_mem_req", bus.mem_req, 0);
    chk_quiet("flush_idle", 0);
    next();
    bus.flush_if = 0;
    do_txn(1, 0, 0, 0, 32'h1000_00C0, 0, 0, 32'hC0, 0, 0, 1, 0, -1, -1);
    // flush during a D burst must not disturb it
    do_txn(0, 1, 0, 1, 0, 32'h2000_0100, 0, 32'hE0, 1, 0, 1, 0, 0, -1);
    // reset after beat 2 of a D burst
    do_txn(0, 1, 0, 1, 0, 32'h3000_0000, 0, 32'hD0, 1, 0, 0, 0, -1, 2);
    // ties right after reset: D, I, D, I; then drain the pending D
    for (int t = 0; t < 4; t++)
      do_txn(1, 1, 0, 0, 32'h4000_0000, 32'h5000_0008, 0, 0, 1, 0, 1, 0, -1, -1);
    do_txn(0, 1, 0, 0, 32'h4000_0000, 32'h5000_0008, 0, 0, 0, 1, 1, 0, -1, -1);

    // randomized traffic; a tie loser keeps its request and fields
    pend_i = 0; pend_d = 0;
    for (int n = 0; n < 40; n++) begin
      if (!pend_i) ia = $urandom & ~32'hF;
      if (!pend_d) begin
        da = $urandom; wd = $urandom;
        we = 1'($urandom_range(0, 1)); bu = 1'($urandom_range(0, 1));
      end
      ir = pend_i || ($urandom_range(0, 1) == 1);
      dr = pend_d || ($urandom_range(0, 1) == 1);
      if (!ir && !dr) ir = 1;
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      do_txn(ir, dr, we, bu, ia, da, wd, 0, $urandom_range(0, 3),
             $urandom_range(0, 2), 2, 1'($urandom_range(0, 1)), fa, -1);
      pend_i = ir && last_d;
      pend_d = dr && !last_d;
      if (!pend_i && !pend_d) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
          bus.i_req = 0; bus.d_req = 0;
          bus.mem_data_ok = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("gap_mem_req", bus.mem_req, 0);
          chk_quiet("idle_gap", 0);
          next();
          bus.mem_data_ok = 0;
        end
      end
    end
    bus.i_req = 0; bus.d_req = 0;
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
